time_bcd_seq: RTL and testbench
===============================

Name: time_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter for the clock display path. Converts NCH packed binary fields (e.g. hour/min/sec) into NDIG BCD digits each, using one iterative double-dabble engine per channel. Uses a valid/ready handshake on input and output, and flags values that do not fit in NDIG digits. Sits between the timekeeping counters and the 7-segment digit mux.

Parameters:
NCH, 3, number of channels (1..8); channel 0 occupies the LSBs of in_data.
IN_W, 6, binary width per channel (1..32).
NDIG, 2, BCD digits per channel (1..10).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept; high only in IDLE.
in_data  in  NCH*IN_W  channel c at [c*IN_W +: IN_W].
out_valid  out  1  out_bcd/out_ovf hold a completed result.
out_ready  in  1  downstream accepts the result.
out_bcd  out  NCH*NDIG*4  channel c, digit d (d=0 is ones) at [(c*NDIG+d)*4 +: 4].
out_ovf  out  NCH  channel c value >= 10^NDIG.
busy  out  1  state != IDLE.

Behaviour:
- FSM states IDLE, SHIFT, DONE.
- Reset values: state IDLE, out_valid 0, out_bcd 0, out_ovf 0, busy 0. in_ready is 1 in the cycle after reset.
- in_ready = (state==IDLE), combinational from state.
- Accept: in_valid && in_ready at edge k. On that edge, latch in_data, clear the BCD scratch, load bit counter = IN_W, compute ovf[c] = (data_c >= 10^NDIG), then go to SHIFT.
- SHIFT: each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 and the counter decrements. After IN_W SHIFT cycles, go to DONE.
- Entering DONE: register results to out_bcd/out_ovf. A channel with ovf=1 outputs all digits 4'h9 (saturate).
- out_valid is high exactly while in DONE. First high is IN_W+1 cycles after the accept edge (7 for defaults).
- DONE stays put until out_ready=1, then goes to IDLE. No back-to-back accept in the same cycle: minimum issue interval is IN_W+2 cycles.
- in_valid while not in IDLE is ignored; in_data is not sampled.
- out_bcd/out_ovf hold their last value after leaving DONE, until the next DONE load.
- Reset in any state (including mid-SHIFT) aborts: state returns to IDLE and outputs return to reset values on the next edge.
- IN_W=1: a single SHIFT cycle; the result equals the input bit.
- Arithmetic: the scratch register is NDIG*4 bits. Bits shifted out above digit NDIG-1 are discarded; correctness for overflowing values comes only from the saturation rule.

Optional Feature:
Macro TIME_BCD_BLANK_EN.
- Defined: leading-zero digits of each channel are replaced with 4'hF (blank code for the segment decoder), from digit NDIG-1 down to, but never including, digit 0. Overflowed channels are not blanked.
- Undefined: leading zeros are output as 4'h0. This is the same RTL with the blanking logic compiled out.

Decomposition:
- Package time_bcd_pkg holds:
  - state enum (IDLE/SHIFT/DONE)
  - BCD_BLANK = 4'hF, BCD_NINE = 4'h9
  - constant function pow10(n) for the overflow threshold
  - function clog2 for counter width
- Sub-module dd_engine: one channel's double-dabble datapath (scratch, add-3, shift), instantiated NCH times via generate. The FSM and counter stay in the top.

Test Plan:
- Defaults; in_data {sec=7, min=59, hour=23}, out_ready=1 -> out_valid 7 cycles after accept; out_bcd digits hour 2,3 / min 5,9 / sec 0,7; out_ovf=0.
- Channel 0 = 63 (IN_W=6, NDIG=2) -> digits 6,3. Then NDIG=1 build with value 12 -> digit 9, out_ovf[0]=1.
- out_ready held 0 for 10 cycles after out_valid -> out_valid and out_bcd stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, in_ready=1.
- rst asserted on the 3rd SHIFT cycle -> next cycle state IDLE, out_valid=0, out_bcd=0, busy=0. Then a fresh conversion of 45 -> 4,5.
- All-zero input -> digits 0,0. With TIME_BCD_BLANK_EN -> digit1=4'hF, digit0=0. Input 5 with the macro -> F,5.
- Parametric: NCH=1, IN_W=20, NDIG=7, value 999999 -> digits 0,9,9,9,9,9,9; out_valid 21 cycles after accept.

Source files
------------

// File: rtl/time_bcd_pkg.sv
// time_bcd_pkg: shared FSM state type, BCD codes and constant helpers for time_bcd_seq
package time_bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE = 4'h9;
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dd_engine.sv
// dd_engine: one channel's double-dabble datapath (load din, add-3 + shift per cycle; nxt is the scratch after the current shift)
module dd_engine #(
  parameter int IN_W = 6,
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [IN_W-1:0]   din,
  output logic [NDIG*4-1:0] nxt
);
  localparam int BW = NDIG * 4;
  logic [IN_W-1:0] bin;
  logic [BW-1:0] scr, adj;
  always_comb begin
    adj = scr;
    for (int d = 0; d < NDIG; d++)
      adj[d*4 +: 4] = (scr[d*4 +: 4] >= 4'd5) ? scr[d*4 +: 4] + 4'd3 : scr[d*4 +: 4];
  end
  assign nxt = BW'({adj, bin[IN_W-1]});
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      scr <= '0;
    end else if (load) begin
      bin <= din;
      scr <= '0;
    end else if (shift) begin
      bin <= bin << 1;
      scr <= nxt;
    end
  end
endmodule

// File: rtl/time_bcd_seq.sv
// time_bcd_seq: NCH-channel sequential binary-to-BCD converter (clk, rst, in_valid/in_ready/in_data -> out_valid/out_ready/out_bcd/out_ovf, busy); TIME_BCD_BLANK_EN blanks leading zeros with 4'hF
module time_bcd_seq
  import time_bcd_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int IN_W = 6,
  parameter int NDIG = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*IN_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*NDIG*4-1:0]  out_bcd,
  output logic [NCH-1:0]         out_ovf,
  output logic                   busy
);
  localparam int CW = clog2(IN_W + 1);
  localparam int BW = NDIG * 4;
  localparam logic [63:0] LIMIT = pow10(NDIG);
  state_t state;
  logic [CW-1:0] cnt;
  logic [NCH-1:0] ovf_r, ovf_nxt;
  logic [BW-1:0] nxt [NCH];
  logic [NCH*BW-1:0] fmt;
  logic [3:0] nib;
  logic load;
`ifdef TIME_BCD_BLANK_EN
  logic lead;
`endif
  assign in_ready = state == IDLE;
  assign busy = !in_ready;
  assign out_valid = state == DONE;
  assign load = in_ready && in_valid;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dd_engine #(.IN_W(IN_W), .NDIG(NDIG)) u_dd (
      .clk(clk),
      .rst(rst),
      .load(load),
      .shift(state == SHIFT),
      .din(in_data[c*IN_W +: IN_W]),
      .nxt(nxt[c])
    );
  end
  always_comb begin
    ovf_nxt = '0;
    for (int c = 0; c < NCH; c++) ovf_nxt[c] = 64'(in_data[c*IN_W +: IN_W]) >= LIMIT;
  end
  always_comb begin
    fmt = '0;
    nib = '0;
`ifdef TIME_BCD_BLANK_EN
    lead = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
`ifdef TIME_BCD_BLANK_EN
      lead = 1'b1;
`endif
      for (int d = NDIG - 1; d >= 0; d--) begin
        nib = nxt[c][d*4 +: 4];
`ifdef TIME_BCD_BLANK_EN
        fmt[(c*NDIG+d)*4 +: 4] = ovf_r[c] ? BCD_NINE : (lead && nib == 4'd0 && d != 0) ? BCD_BLANK : nib;
        lead = lead && nib == 4'd0;
`else
        fmt[(c*NDIG+d)*4 +: 4] = ovf_r[c] ? BCD_NINE : nib;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ovf_r <= '0;
      out_bcd <= '0;
      out_ovf <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= SHIFT;
          cnt <= CW'(IN_W);
          ovf_r <= ovf_nxt;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            out_bcd <= fmt;
            out_ovf <= ovf_r;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_time_bcd_seq.sv
// tb_time_bcd_seq: randomized self-checking bench for time_bcd_seq against a decimal-arithmetic reference model
module tb_time_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [4];
  logic ordy [4];
  logic [19:0] idat [4];
  logic ir [4], ovv [4], bsy [4];
  logic [27:0] bcd [4];
  logic [2:0] ovf [4];
  logic [23:0] b0;
  logic [2:0] f0;
  logic [27:0] b1;
  logic [0:0] f1;
  logic [7:0] b2, b3;
  logic [1:0] f2, f3;
  int nc [4] = '{3, 1, 2, 2};
  int iw [4] = '{6, 20, 4, 1};
  int nd [4] = '{2, 7, 1, 1};
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  time_bcd_seq u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][17:0]),
    .out_valid(ovv[0]), .out_ready(ordy[0]), .out_bcd(b0), .out_ovf(f0), .busy(bsy[0]));
  time_bcd_seq #(.NCH(1), .IN_W(20), .NDIG(7)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][19:0]),
    .out_valid(ovv[1]), .out_ready(ordy[1]), .out_bcd(b1), .out_ovf(f1), .busy(bsy[1]));
  time_bcd_seq #(.NCH(2), .IN_W(4), .NDIG(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][7:0]),
    .out_valid(ovv[2]), .out_ready(ordy[2]), .out_bcd(b2), .out_ovf(f2), .busy(bsy[2]));
  time_bcd_seq #(.NCH(2), .IN_W(1), .NDIG(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(idat[3][1:0]),
    .out_valid(ovv[3]), .out_ready(ordy[3]), .out_bcd(b3), .out_ovf(f3), .busy(bsy[3]));

  assign bcd[0] = 28'(b0);
  assign bcd[1] = b1;
  assign bcd[2] = 28'(b2);
  assign bcd[3] = 28'(b3);
  assign ovf[0] = f0;
  assign ovf[1] = 3'(f1);
  assign ovf[2] = 3'(f2);
  assign ovf[3] = 3'(f3);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bit 40 = overflow, digit i at [i*4 +: 4]
  function automatic logic [40:0] ref_conv(input longint v, input int n);
    longint p;
    logic [39:0] r;
    logic [3:0] dg;
    p = 1;
    r = '0;
    for (int i = 0; i < n; i++) p *= 10;
    if (v >= p) begin
      for (int i = 0; i < n; i++) r[i*4 +: 4] = 4'h9;
      return {1'b1, r};
    end
    p = 1;
    for (int i = 0; i < n; i++) begin
      dg = 4'((v / p) % 10);
`ifdef TIME_BCD_BLANK_EN
      if (i > 0 && v < p) dg = 4'hF;
`endif
      r[i*4 +: 4] = dg;
      p *= 10;
    end
    return {1'b0, r};
  endfunction

  task automatic run(input int id, input logic [19:0] d, input int hold);
    int lat;
    longint v;
    logic [40:0] r;
    logic [63:0] mask;
    logic [27:0] held;
    logic [2:0] held_ovf;
    check($sformatf("d%0d_in_ready_pre", id), 64'(ir[id]), 64'd1);
    iv[id] = 1'b1;
    idat[id] = d;
    ordy[id] = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      iv[id] = 1'b0;
      lat++;
    end while (!ovv[id] && lat < 60);
    check($sformatf("d%0d_latency", id), 64'(lat), 64'(iw[id] + 1));
    mask = (64'd1 << (nd[id] * 4)) - 1;
    for (int c = 0; c < nc[id]; c++) begin
      v = (longint'(d) >> (c * iw[id])) & ((64'd1 << iw[id]) - 1);
      r = ref_conv(v, nd[id]);
      check($sformatf("d%0d_bcd_c%0d_v%0d", id, c, v), (64'(bcd[id]) >> (c * nd[id] * 4)) & mask, 64'(r[39:0]) & mask);
      check($sformatf("d%0d_ovf_c%0d_v%0d", id, c, v), 64'(ovf[id][c]), 64'(r[40]));
    end
    held = bcd[id];
    held_ovf = ovf[id];
    for (int i = 0; i < hold; i++) begin
      iv[id] = 1'b1;
      idat[id] = ~d;
      @(negedge clk);
      check($sformatf("d%0d_stall_valid", id), 64'(ovv[id]), 64'd1);
      check($sformatf("d%0d_stall_ready", id), 64'(ir[id]), 64'd0);
      check($sformatf("d%0d_stall_bcd", id), 64'(bcd[id]), 64'(held));
    end
    iv[id] = 1'b0;
    ordy[id] = 1'b1;
    @(negedge clk);
    check($sformatf("d%0d_idle_valid", id), 64'(ovv[id]), 64'd0);
    check($sformatf("d%0d_idle_ready", id), 64'(ir[id]), 64'd1);
    check($sformatf("d%0d_idle_busy", id), 64'(bsy[id]), 64'd0);
    check($sformatf("d%0d_hold_bcd", id), 64'(bcd[id]), 64'(held));
    check($sformatf("d%0d_hold_ovf", id), 64'(ovf[id]), 64'(held_ovf));
  endtask

  task automatic reset_checks();
    for (int id = 0; id < 4; id++) begin
      check($sformatf("d%0d_rst_valid", id), 64'(ovv[id]), 64'd0);
      check($sformatf("d%0d_rst_bcd", id), 64'(bcd[id]), 64'd0);
      check($sformatf("d%0d_rst_ovf", id), 64'(ovf[id]), 64'd0);
      check($sformatf("d%0d_rst_busy", id), 64'(bsy[id]), 64'd0);
      check($sformatf("d%0d_rst_ready", id), 64'(ir[id]), 64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      idat[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_checks();
    run(0, {6'd23, 6'd59, 6'd7}, 0);
    run(0, 20'd63, 0);
    run(0, {6'd12, 6'd34, 6'd56}, 10);
    iv[0] = 1'b1;
    idat[0] = {6'd40, 6'd41, 6'd42};
    @(negedge clk);
    iv[0] = 1'b0;
    check("d0_shift_busy", 64'(bsy[0]), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_checks();
    run(0, 20'd45, 0);
    run(0, 20'd0, 0);
    run(0, 20'd5, 0);
    run(1, 20'd999999, 0);
    run(1, 20'd0, 0);
    run(1, 20'hFFFFF, 1);
    run(2, 20'd12, 0);
    run(2, {12'd0, 4'd9, 4'd10}, 2);
    run(3, 20'd1, 0);
    run(3, 20'd2, 0);
    run(3, 20'd3, 1);
    for (int i = 0; i < 60; i++)
      run(int'($urandom_range(0, 3)), 20'($urandom), int'($urandom_range(0, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
